// File: rtl/ulpi_pkg.sv
// ULPI link-side constants: TXCMD encodings, immediate register addresses and
// sequencer state codes shared by the register-access controller.
package ulpi_pkg;

   localparam logic [1:0] TXCMD_REGW = 2'b10;
   localparam logic [1:0] TXCMD_REGR = 2'b11;
   localparam logic [7:0] TXCMD_NOOP = 8'h00;

   localparam logic [5:0] ADDR_FUNC_CTRL = 6'h04;
   localparam logic [5:0] ADDR_IFC_CTRL  = 6'h07;
   localparam logic [5:0] ADDR_OTG_CTRL  = 6'h0A;

   typedef logic [3:0] state_t;

   localparam state_t ST_IDLE       = 4'd0;
   localparam state_t ST_WR_CMD     = 4'd1;
   localparam state_t ST_WR_DATA    = 4'd2;
   localparam state_t ST_WR_STP     = 4'd3;
   localparam state_t ST_RD_CMD     = 4'd4;
   localparam state_t ST_RD_TURN    = 4'd5;
   localparam state_t ST_RD_DATA    = 4'd6;
   localparam state_t ST_RD_END     = 4'd7;
   localparam state_t ST_ABORT_WAIT = 4'd8;

   function automatic logic is_cmd_state(input state_t st);
      return (st == ST_WR_CMD) || (st == ST_RD_CMD);
   endfunction

endpackage

// File: rtl/ulpi_reg_ctrl.sv
// ULPI register-access sequencer: turns register requests into TXCMD/data/STP
// sequences, follows DIR turnarounds, retries after PHY bus seizure, reports RXCMDs.
//
// state      | meaning
// IDLE       | drive NOOP, accept a request when the bus is ours and settled
// WR_CMD     | drive REGW TXCMD, wait for NXT (timeout counted here)
// WR_DATA    | drive write data until NXT
// WR_STP     | one-cycle STP, completion pulse
// RD_CMD     | drive REGR TXCMD, wait for NXT (timeout counted here)
// RD_TURN    | released bus, wait for PHY to take DIR
// RD_DATA    | PHY drives register value, capture it
// RD_END     | wait for DIR back low and settled
// ABORT_WAIT | PHY seized the bus mid-command, wait then re-issue
module ulpi_reg_ctrl
   import ulpi_pkg::*;
#(
   parameter int NXT_TIMEOUT = 255
) (
   input  logic       CLK,
   input  logic       NRST,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_write,
   input  logic [5:0] req_addr,
   input  logic [7:0] req_wdata,
   output logic       rsp_valid,
   output logic       rsp_err,
   output logic [7:0] rsp_rdata,
   output logic       rxcmd_valid,
   output logic [7:0] rxcmd_data,
   input  logic       ulpi_dir,
   input  logic       ulpi_nxt,
   input  logic [7:0] ulpi_data_i,
   output logic [7:0] ulpi_data_o,
   output logic       ulpi_data_oe,
   output logic       ulpi_stp
);

   localparam logic [7:0] TO_LAST = 8'(NXT_TIMEOUT - 1);

   state_t     r_state;
   state_t     w_state_nxt;
   logic       r_dir_q;
   logic [7:0] r_to_cnt;
   logic       r_req_write;
   logic [5:0] r_req_addr;
   logic [7:0] r_req_wdata;
   logic       r_rsp_valid;
   logic       r_rsp_err;
   logic [7:0] r_rsp_rdata;
   logic       r_rxcmd_valid;
   logic [7:0] r_rxcmd_data;

   logic       w_accept;
   logic       w_cmd_state;
   logic       w_to_hit;
   logic       w_drives;
   logic       w_bus_settled_low;

   assign w_bus_settled_low = ~ulpi_dir & ~r_dir_q;
   assign req_ready   = (r_state == ST_IDLE) & w_bus_settled_low;
   assign w_accept    = req_valid & req_ready;
   assign w_cmd_state = is_cmd_state(r_state);
   assign w_to_hit    = w_cmd_state & ~ulpi_dir & ~ulpi_nxt & (r_to_cnt == TO_LAST);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:
            if (w_accept) w_state_nxt = req_write ? ST_WR_CMD : ST_RD_CMD;
         ST_WR_CMD:
            if (ulpi_dir)      w_state_nxt = ST_ABORT_WAIT;
            else if (ulpi_nxt) w_state_nxt = ST_WR_DATA;
            else if (w_to_hit) w_state_nxt = ST_IDLE;
         ST_WR_DATA:
            if (ulpi_dir)      w_state_nxt = ST_ABORT_WAIT;
            else if (ulpi_nxt) w_state_nxt = ST_WR_STP;
         ST_WR_STP:
            w_state_nxt = ST_IDLE;
         ST_RD_CMD:
            if (ulpi_dir)      w_state_nxt = ST_ABORT_WAIT;
            else if (ulpi_nxt) w_state_nxt = ST_RD_TURN;
            else if (w_to_hit) w_state_nxt = ST_IDLE;
         ST_RD_TURN:
            if (ulpi_dir & ~r_dir_q) w_state_nxt = ST_RD_DATA;
         ST_RD_DATA:
            w_state_nxt = ST_RD_END;
         ST_RD_END:
            if (w_bus_settled_low) w_state_nxt = ST_IDLE;
         ST_ABORT_WAIT:
            if (w_bus_settled_low) w_state_nxt = r_req_write ? ST_WR_CMD : ST_RD_CMD;
         default:
            w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
         r_state     <= ST_IDLE;
         r_dir_q     <= 1'b1;
         r_to_cnt    <= 8'd0;
         r_req_write <= 1'b0;
         r_req_addr  <= 6'd0;
         r_req_wdata <= 8'd0;
      end else begin
         r_state <= w_state_nxt;
         r_dir_q <= ulpi_dir;
         if (w_state_nxt != r_state)
            r_to_cnt <= 8'd0;
         else if (w_cmd_state & ~ulpi_dir & ~ulpi_nxt)
            r_to_cnt <= r_to_cnt + 8'd1;
         if (w_accept) begin
            r_req_write <= req_write;
            r_req_addr  <= req_addr;
            r_req_wdata <= req_wdata;
         end
      end
   end

   // Response and RXCMD reporting are registered one-cycle pulses.
   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
         r_rsp_valid   <= 1'b0;
         r_rsp_err     <= 1'b0;
         r_rsp_rdata   <= 8'd0;
         r_rxcmd_valid <= 1'b0;
         r_rxcmd_data  <= 8'd0;
      end else begin
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         if ((r_state == ST_WR_DATA) && (w_state_nxt == ST_WR_STP))
            r_rsp_valid <= 1'b1;
         if (r_state == ST_RD_DATA) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= ulpi_data_i;
         end
         if (w_to_hit) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
         end
         r_rxcmd_valid <= ulpi_dir & r_dir_q & ~ulpi_nxt & (r_state != ST_RD_DATA);
         if (ulpi_dir & r_dir_q & ~ulpi_nxt & (r_state != ST_RD_DATA))
            r_rxcmd_data <= ulpi_data_i;
      end
   end

   always_comb begin
      ulpi_data_o = TXCMD_NOOP;
      w_drives    = 1'b0;
      case (r_state)
         ST_IDLE:    w_drives = 1'b1;
         ST_WR_CMD: begin
            ulpi_data_o = {TXCMD_REGW, r_req_addr};
            w_drives    = 1'b1;
         end
         ST_WR_DATA: begin
            ulpi_data_o = r_req_wdata;
            w_drives    = 1'b1;
         end
         ST_WR_STP:  w_drives = 1'b1;
         ST_RD_CMD: begin
            ulpi_data_o = {TXCMD_REGR, r_req_addr};
            w_drives    = 1'b1;
         end
         default:    w_drives = 1'b0;
      endcase
   end

   // DIR gates the enable combinationally; dir_q keeps the link off the turnaround cycle.
   assign ulpi_data_oe = w_drives & ~ulpi_dir & ~r_dir_q;
   assign ulpi_stp     = (r_state == ST_WR_STP);
   assign rsp_valid    = r_rsp_valid;
   assign rsp_err      = r_rsp_err;
   assign rsp_rdata    = r_rsp_rdata;
   assign rxcmd_valid  = r_rxcmd_valid;
   assign rxcmd_data   = r_rxcmd_data;

endmodule

// File: tb/tb_ulpi_reg_ctrl.sv
// Self-checking bench for ulpi_reg_ctrl: scripted PHY behaviour, response and
// RXCMD scoreboards checked by negedge monitors, plus direct pin checks.
module tb_ulpi_reg_ctrl;
   import ulpi_pkg::*;

   logic       CLK = 1'b0;
   logic       NRST;
   logic       req_valid, req_ready, req_write;
   logic [5:0] req_addr;
   logic [7:0] req_wdata;
   logic       rsp_valid, rsp_err;
   logic [7:0] rsp_rdata;
   logic       rxcmd_valid;
   logic [7:0] rxcmd_data;
   logic       ulpi_dir, ulpi_nxt;
   logic [7:0] ulpi_data_i, ulpi_data_o;
   logic       ulpi_data_oe, ulpi_stp;

   typedef struct {
      logic       err;
      logic       rd;
      logic [7:0] data;
   } rsp_exp_t;

   rsp_exp_t   rsp_q[$];
   logic [7:0] rx_q[$];
   rsp_exp_t   rsp_e;
   logic [7:0] rx_e;
   int         n_tests = 0;
   int         n_fail  = 0;

   ulpi_reg_ctrl #(.NXT_TIMEOUT(8)) u_dut (
      .CLK          (CLK),
      .NRST         (NRST),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_err      (rsp_err),
      .rsp_rdata    (rsp_rdata),
      .rxcmd_valid  (rxcmd_valid),
      .rxcmd_data   (rxcmd_data),
      .ulpi_dir     (ulpi_dir),
      .ulpi_nxt     (ulpi_nxt),
      .ulpi_data_i  (ulpi_data_i),
      .ulpi_data_o  (ulpi_data_o),
      .ulpi_data_oe (ulpi_data_oe),
      .ulpi_stp     (ulpi_stp)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   always @(negedge CLK) begin
      if (NRST === 1'b1 && rsp_valid === 1'b1) begin
         if (rsp_q.size() == 0) chk("rsp_extra", rsp_valid, 0);
         else begin
            rsp_e = rsp_q.pop_front();
            chk("rsp_err", rsp_err, rsp_e.err);
            if (rsp_e.rd) chk("rsp_rdata", rsp_rdata, rsp_e.data);
         end
      end
      if (NRST === 1'b1 && rxcmd_valid === 1'b1) begin
         if (rx_q.size() == 0) chk("rxcmd_extra", rxcmd_valid, 0);
         else begin
            rx_e = rx_q.pop_front();
            chk("rxcmd_data", rxcmd_data, rx_e);
         end
      end
   end

   // Write with NXT held high from the request onwards; entered at a drive point in IDLE.
   task automatic wr_fast(input logic [5:0] a, input logic [7:0] d);
      req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d; ulpi_nxt = 1'b1;
      rsp_q.push_back('{err: 1'b0, rd: 1'b0, data: 8'h00});
      @(negedge CLK); chk("wr_ready", req_ready, 1);
      cyc(); req_valid = 1'b0;
      @(negedge CLK); chk("wr_txcmd", ulpi_data_o, {TXCMD_REGW, a}); chk("wr_txcmd_oe", ulpi_data_oe, 1);
      cyc();
      @(negedge CLK); chk("wr_data", ulpi_data_o, d); chk("wr_data_stp", ulpi_stp, 0);
      cyc();
      @(negedge CLK); chk("wr_stp", ulpi_stp, 1); chk("wr_stp_data", ulpi_data_o, 0);
      chk("wr_rsp_valid", rsp_valid, 1);
      cyc(); ulpi_nxt = 1'b0;
      @(negedge CLK); chk("wr_end_stp", ulpi_stp, 0); chk("wr_end_ready", req_ready, 1);
      chk("wr_end_rsp", rsp_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int n_rdy;
      NRST = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 6'd0; req_wdata = 8'd0;
      ulpi_dir = 1'b0; ulpi_nxt = 1'b0; ulpi_data_i = 8'h00;
      repeat (3) cyc();
      @(negedge CLK);
      chk("rst_ready", req_ready, 0);
      chk("rst_oe", ulpi_data_oe, 0);
      chk("rst_stp", ulpi_stp, 0);
      chk("rst_data_o", ulpi_data_o, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rxcmd_valid", rxcmd_valid, 0);
      chk("rst_rxcmd_data", rxcmd_data, 0);
      cyc(); NRST = 1'b1;
      @(negedge CLK); chk("post_rst_ready_dirq", req_ready, 0);
      cyc();
      @(negedge CLK); chk("idle_ready", req_ready, 1); chk("idle_oe", ulpi_data_oe, 1);
      chk("idle_noop", ulpi_data_o, TXCMD_NOOP);

      // Write FUNC_CTRL = 0x45 with NXT high.
      cyc(); wr_fast(ADDR_FUNC_CTRL, 8'h45);

      // Read OTG_CTRL, PHY returns 0x3C.
      cyc();
      req_valid = 1'b1; req_write = 1'b0; req_addr = ADDR_OTG_CTRL; ulpi_nxt = 1'b0;
      rsp_q.push_back('{err: 1'b0, rd: 1'b1, data: 8'h3C});
      @(negedge CLK); chk("rd_ready", req_ready, 1);
      cyc(); req_valid = 1'b0; ulpi_nxt = 1'b1;
      @(negedge CLK); chk("rd_txcmd", ulpi_data_o, 8'hCA); chk("rd_txcmd_oe", ulpi_data_oe, 1);
      cyc(); ulpi_nxt = 1'b0; ulpi_dir = 1'b1;
      @(negedge CLK); chk("rd_turn_oe", ulpi_data_oe, 0);
      cyc(); ulpi_data_i = 8'h3C;
      @(negedge CLK); chk("rd_data_oe", ulpi_data_oe, 0); chk("rd_data_no_rsp", rsp_valid, 0);
      cyc(); ulpi_dir = 1'b0; ulpi_data_i = 8'h00;
      @(negedge CLK); chk("rd_rsp_valid", rsp_valid, 1); chk("rd_rsp_rdata", rsp_rdata, 8'h3C);
      chk("rd_end_oe", ulpi_data_oe, 0);
      cyc();
      @(negedge CLK); chk("rd_back_turn_ready", req_ready, 0); chk("rd_back_turn_rsp", rsp_valid, 0);
      cyc();
      @(negedge CLK); chk("rd_done_ready", req_ready, 1);

      // PHY seizes the bus during WR_CMD, sends RXCMD 0x40, write is re-issued.
      cyc();
      req_valid = 1'b1; req_write = 1'b1; req_addr = ADDR_FUNC_CTRL; req_wdata = 8'h5A; ulpi_nxt = 1'b0;
      rsp_q.push_back('{err: 1'b0, rd: 1'b0, data: 8'h00});
      @(negedge CLK); chk("ab_ready", req_ready, 1);
      cyc(); req_valid = 1'b0;
      @(negedge CLK); chk("ab_txcmd", ulpi_data_o, 8'h84); chk("ab_txcmd_oe", ulpi_data_oe, 1);
      cyc(); ulpi_dir = 1'b1;
      @(negedge CLK); chk("ab_oe_release", ulpi_data_oe, 0);
      cyc(); ulpi_data_i = 8'h40;
      rx_q.push_back(8'h40);
      @(negedge CLK); chk("ab_wait_oe", ulpi_data_oe, 0);
      cyc(); ulpi_dir = 1'b0; ulpi_data_i = 8'h00;
      @(negedge CLK); chk("ab_rxcmd_valid", rxcmd_valid, 1); chk("ab_low1_oe", ulpi_data_oe, 0);
      cyc();
      @(negedge CLK); chk("ab_low2_oe", ulpi_data_oe, 0); chk("ab_low2_stp", ulpi_stp, 0);
      cyc(); ulpi_nxt = 1'b1;
      @(negedge CLK); chk("ab_reissue", ulpi_data_o, 8'h84); chk("ab_reissue_oe", ulpi_data_oe, 1);
      cyc();
      @(negedge CLK); chk("ab_data", ulpi_data_o, 8'h5A);
      cyc();
      @(negedge CLK); chk("ab_stp", ulpi_stp, 1); chk("ab_rsp_valid", rsp_valid, 1);
      chk("ab_rxcmd_held", rxcmd_data, 8'h40);
      cyc(); ulpi_nxt = 1'b0;
      @(negedge CLK); chk("ab_end_ready", req_ready, 1);

      // NXT never arrives: timeout after 8 WR_CMD cycles.
      cyc();
      req_valid = 1'b1; req_write = 1'b1; req_addr = ADDR_IFC_CTRL; req_wdata = 8'h22;
      rsp_q.push_back('{err: 1'b1, rd: 1'b0, data: 8'h00});
      @(negedge CLK); chk("to_ready", req_ready, 1);
      cyc(); req_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK);
         chk("to_cmd_held", ulpi_data_o, 8'h87);
         chk("to_no_rsp", rsp_valid, 0);
         cyc();
      end
      @(negedge CLK); chk("to_rsp_valid", rsp_valid, 1); chk("to_rsp_err", rsp_err, 1);
      chk("to_idle_ready", req_ready, 1); chk("to_idle_noop", ulpi_data_o, TXCMD_NOOP);
      cyc();
      @(negedge CLK); chk("to_rsp_pulse", rsp_valid, 0);

      // DIR high (RX data, NXT high) for 100 cycles after reset release.
      cyc(); NRST = 1'b0; ulpi_dir = 1'b1; ulpi_nxt = 1'b1; ulpi_data_i = 8'hA5;
      cyc(); NRST = 1'b1;
      req_valid = 1'b1; req_write = 1'b1; req_addr = ADDR_OTG_CTRL; req_wdata = 8'h11;
      n_rdy = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge CLK);
         if (req_ready) n_rdy++;
         cyc();
      end
      chk("dirhigh_ready_cycles", n_rdy, 0);
      ulpi_dir = 1'b0; ulpi_nxt = 1'b0; ulpi_data_i = 8'h00;
      @(negedge CLK); chk("dirlow1_ready", req_ready, 0);
      cyc();
      rsp_q.push_back('{err: 1'b0, rd: 1'b0, data: 8'h00});
      @(negedge CLK); chk("dirlow2_ready", req_ready, 1);
      cyc(); req_valid = 1'b0; ulpi_nxt = 1'b1;
      @(negedge CLK); chk("dh_txcmd", ulpi_data_o, 8'h8A);
      cyc();
      @(negedge CLK); chk("dh_data", ulpi_data_o, 8'h11);
      cyc();
      @(negedge CLK); chk("dh_stp", ulpi_stp, 1); chk("dh_rsp_valid", rsp_valid, 1);
      cyc(); ulpi_nxt = 1'b0;
      @(negedge CLK); chk("dh_end_ready", req_ready, 1);

      // Reset pulse while in WR_DATA; no STP, no response; next write is clean.
      cyc();
      req_valid = 1'b1; req_write = 1'b1; req_addr = ADDR_FUNC_CTRL; req_wdata = 8'h77; ulpi_nxt = 1'b0;
      @(negedge CLK); chk("rp_ready", req_ready, 1);
      cyc(); req_valid = 1'b0; ulpi_nxt = 1'b1;
      cyc(); ulpi_nxt = 1'b0;
      @(negedge CLK); chk("rp_wr_data", ulpi_data_o, 8'h77);
      #2 NRST = 1'b0;
      #1;
      chk("rp_stp", ulpi_stp, 0); chk("rp_oe", ulpi_data_oe, 0);
      chk("rp_data_o", ulpi_data_o, 0); chk("rp_ready_low", req_ready, 0);
      cyc(); NRST = 1'b1;
      @(negedge CLK); chk("rp_post_ready", req_ready, 0); chk("rp_post_stp", ulpi_stp, 0);
      chk("rp_post_rsp", rsp_valid, 0);
      cyc();
      @(negedge CLK); chk("rp_idle_ready", req_ready, 1);
      cyc(); wr_fast(ADDR_FUNC_CTRL, 8'h9C);

      cyc(); cyc();
      chk("rsp_q_empty", rsp_q.size(), 0);
      chk("rx_q_empty", rx_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
